// File: rtl/axi_mm2s_pkg.sv
`default_nettype none
// ============================================================================
// Module : axi_mm2s_pkg
// Desc   : Command/status field positions, AXI constants and FSM states for
//          the MM2S command engine.
// Rev    : 1.0  initial release
// ============================================================================
package axi_mm2s_pkg;

   // Command word layout
   localparam int CMD_BTT_MSB    = 22;
   localparam int CMD_EOF_BIT    = 30;
   localparam int CMD_ADDR_LSB   = 32;
   localparam int CMD_ADDR_MSB   = 63;
   localparam int CMD_TAG_LSB    = 64;
   localparam int CMD_TAG_MSB    = 67;

   // Status word layout
   localparam int STS_OKAY_BIT   = 7;
   localparam int STS_SLVERR_BIT = 6;
   localparam int STS_DECERR_BIT = 5;
   localparam int STS_INTERR_BIT = 4;

   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_SLV   = 2'b10;
   localparam logic [1:0] AXI_RESP_DEC   = 2'b11;

   localparam int PAGE_BYTES = 4096;
   localparam int PAGE_WORDS = PAGE_BYTES / 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_ADDR  = 3'd2,
      ST_DATA  = 3'd3,
      ST_STS   = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/axi_mm2s_burst_calc.sv
`default_nettype none
// ============================================================================
// Module : axi_mm2s_burst_calc
// Desc   : ARLEN = min(words_left, max burst, words to 4 KB page end) - 1.
// Rev    : 1.0  initial release
// ============================================================================
module axi_mm2s_burst_calc
   import axi_mm2s_pkg::*;
#(
   parameter int C_MAX_BURST_LEN = 16
) (
   input  logic [9:0]  page_word_off,
   input  logic [20:0] words_left,
   output logic [7:0]  arlen
);

   logic [10:0] page_words;
   logic [20:0] beats;

   always_comb begin
      // 1..1024 words remain before the next 4 KB page boundary
      page_words = 11'(PAGE_WORDS) - {1'b0, page_word_off};
      beats      = words_left;
      if (beats > 21'(C_MAX_BURST_LEN)) begin
         beats = 21'(C_MAX_BURST_LEN);
      end
      if (beats > {10'd0, page_words}) begin
         beats = {10'd0, page_words};
      end
      arlen = 8'(beats - 21'd1);
   end

endmodule
`default_nettype wire

// File: rtl/axi_mm2s_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module : axi_mm2s_cmd_engine
// Desc   : DataMover-style MM2S responder: commands in, INCR read bursts out,
//          read data streamed through, one status word per command.
// Rev    : 1.0  initial release
// ============================================================================
module axi_mm2s_cmd_engine
   import axi_mm2s_pkg::*;
#(
   parameter int         C_M_AXI_ADDR_WIDTH      = 32,
   parameter int         C_M_AXI_DATA_WIDTH      = 32,
   parameter int         C_S_AXIS_CMD_DATA_WIDTH = 72,
   parameter int         C_M_AXIS_STS_DATA_WIDTH = 8,
   parameter int         C_MAX_BURST_LEN         = 16,
   parameter logic [3:0] C_ARCACHE               = 4'b0011,
   parameter logic [4:0] C_ARUSER                = 5'b00001
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 S_AXIS_CMD_TVALID,
   output logic                                 S_AXIS_CMD_TREADY,
   input  logic [C_S_AXIS_CMD_DATA_WIDTH-1:0]   S_AXIS_CMD_TDATA,
   output logic                                 M_AXIS_STS_TVALID,
   input  logic                                 M_AXIS_STS_TREADY,
   output logic [C_M_AXIS_STS_DATA_WIDTH-1:0]   M_AXIS_STS_TDATA,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]        M_AXI_ARADDR,
   output logic [7:0]                           M_AXI_ARLEN,
   output logic [2:0]                           M_AXI_ARSIZE,
   output logic [1:0]                           M_AXI_ARBURST,
   output logic [3:0]                           M_AXI_ARCACHE,
   output logic [4:0]                           M_AXI_ARUSER,
   output logic                                 M_AXI_ARVALID,
   input  logic                                 M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]        M_AXI_RDATA,
   input  logic [1:0]                           M_AXI_RRESP,
   input  logic                                 M_AXI_RLAST,
   input  logic                                 M_AXI_RVALID,
   output logic                                 M_AXI_RREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]        M_AXIS_MM2S_TDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]      M_AXIS_MM2S_TKEEP,
   output logic                                 M_AXIS_MM2S_TLAST,
   output logic                                 M_AXIS_MM2S_TVALID,
   input  logic                                 M_AXIS_MM2S_TREADY
);

   state_t                          state_q,      state_d;
   logic [3:0]                      tag_q,        tag_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q,       addr_d;
   logic                            eof_q,        eof_d;
   logic [22:0]                     btt_q,        btt_d;
   logic [20:0]                     words_left_q, words_left_d;
   logic [7:0]                      arlen_q,      arlen_d;
   logic                            arvalid_q,    arvalid_d;
   logic                            sts_valid_q,  sts_valid_d;
   logic                            slverr_q,     slverr_d;
   logic                            decerr_q,     decerr_d;
   logic                            interr_q,     interr_d;

   logic [7:0]  calc_arlen;
   logic [10:0] burst_bytes;
   logic        r_hs;
   logic        cmd_unused;

   assign cmd_unused  = ^{S_AXIS_CMD_TDATA[71:68], S_AXIS_CMD_TDATA[31],
                          S_AXIS_CMD_TDATA[29:23]};
   assign burst_bytes = {1'b0, arlen_q, 2'b00} + 11'd4;
   assign r_hs        = (state_q == ST_DATA) && M_AXI_RVALID && M_AXIS_MM2S_TREADY;

   // Sized for the burst about to be issued, so AR fields are registered
   axi_mm2s_burst_calc #(
      .C_MAX_BURST_LEN (C_MAX_BURST_LEN)
   ) u_burst_calc (
      .page_word_off (addr_d[11:2]),
      .words_left    (words_left_d),
      .arlen         (calc_arlen)
   );

   always_comb begin
      state_d      = state_q;
      tag_d        = tag_q;
      addr_d       = addr_q;
      eof_d        = eof_q;
      btt_d        = btt_q;
      words_left_d = words_left_q;
      slverr_d     = slverr_q;
      decerr_d     = decerr_q;
      interr_d     = interr_q;
      case (state_q)
         ST_IDLE: begin
            if (S_AXIS_CMD_TVALID) begin
               tag_d   = S_AXIS_CMD_TDATA[CMD_TAG_MSB:CMD_TAG_LSB];
               addr_d  = C_M_AXI_ADDR_WIDTH'(S_AXIS_CMD_TDATA[CMD_ADDR_MSB:CMD_ADDR_LSB]);
               eof_d   = S_AXIS_CMD_TDATA[CMD_EOF_BIT];
               btt_d   = S_AXIS_CMD_TDATA[CMD_BTT_MSB:0];
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if ((btt_q == 23'd0) || (btt_q[1:0] != 2'b00) || (addr_q[1:0] != 2'b00)) begin
               interr_d = 1'b1;
               state_d  = ST_STS;
            end else begin
               words_left_d = btt_q[22:2];
               state_d      = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (M_AXI_ARREADY) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (r_hs) begin
               words_left_d = words_left_q - 21'd1;
               if (M_AXI_RRESP == AXI_RESP_SLV) slverr_d = 1'b1;
               if (M_AXI_RRESP == AXI_RESP_DEC) decerr_d = 1'b1;
               if (M_AXI_RLAST) begin
                  if (words_left_d == 21'd0) begin
                     state_d = ST_STS;
                  end else begin
                     addr_d  = addr_q + C_M_AXI_ADDR_WIDTH'(burst_bytes);
                     state_d = ST_ADDR;
                  end
               end
            end
         end
         ST_STS: begin
            if (M_AXIS_STS_TREADY) begin
               slverr_d = 1'b0;
               decerr_d = 1'b0;
               interr_d = 1'b0;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign arlen_d     = (state_d == ST_ADDR) ? calc_arlen : arlen_q;
   assign arvalid_d   = (state_d == ST_ADDR);
   assign sts_valid_d = (state_d == ST_STS);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         tag_q        <= 4'd0;
         addr_q       <= '0;
         eof_q        <= 1'b0;
         btt_q        <= 23'd0;
         words_left_q <= 21'd0;
         arlen_q      <= 8'd0;
         arvalid_q    <= 1'b0;
         sts_valid_q  <= 1'b0;
         slverr_q     <= 1'b0;
         decerr_q     <= 1'b0;
         interr_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         tag_q        <= tag_d;
         addr_q       <= addr_d;
         eof_q        <= eof_d;
         btt_q        <= btt_d;
         words_left_q <= words_left_d;
         arlen_q      <= arlen_d;
         arvalid_q    <= arvalid_d;
         sts_valid_q  <= sts_valid_d;
         slverr_q     <= slverr_d;
         decerr_q     <= decerr_d;
         interr_q     <= interr_d;
      end
   end

   assign S_AXIS_CMD_TREADY = (state_q == ST_IDLE) && !rst;

   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_ARLEN   = arlen_q;
   assign M_AXI_ARSIZE  = AXI_SIZE_4B;
   assign M_AXI_ARBURST = AXI_BURST_INCR;
   assign M_AXI_ARCACHE = C_ARCACHE;
   assign M_AXI_ARUSER  = C_ARUSER;
   assign M_AXI_ARVALID = arvalid_q;

   // Read channel is a zero-latency pass-through onto the output stream
   assign M_AXI_RREADY       = (state_q == ST_DATA) && M_AXIS_MM2S_TREADY;
   assign M_AXIS_MM2S_TVALID = (state_q == ST_DATA) && M_AXI_RVALID;
   assign M_AXIS_MM2S_TDATA  = M_AXI_RDATA;
   assign M_AXIS_MM2S_TKEEP  = '1;
   assign M_AXIS_MM2S_TLAST  = (state_q == ST_DATA) && M_AXI_RLAST &&
                               (words_left_q == 21'd1) && eof_q;

   assign M_AXIS_STS_TVALID = sts_valid_q;
   assign M_AXIS_STS_TDATA  = C_M_AXIS_STS_DATA_WIDTH'({
                                 !(slverr_q || decerr_q || interr_q),
                                 slverr_q, decerr_q, interr_q, tag_q});

endmodule
`default_nettype wire

// File: tb/tb_axi_mm2s_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module : tb_axi_mm2s_cmd_engine
// Desc   : Directed self-checking bench with a behavioural AXI read slave.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_axi_mm2s_cmd_engine;

   localparam logic [31:0] PAT = 32'hA5A5_5A5A;

   logic        clk = 1'b0;
   logic        rst;
   logic        S_AXIS_CMD_TVALID, S_AXIS_CMD_TREADY;
   logic [71:0] S_AXIS_CMD_TDATA;
   logic        M_AXIS_STS_TVALID, M_AXIS_STS_TREADY;
   logic [7:0]  M_AXIS_STS_TDATA;
   logic [31:0] M_AXI_ARADDR;
   logic [7:0]  M_AXI_ARLEN;
   logic [2:0]  M_AXI_ARSIZE;
   logic [1:0]  M_AXI_ARBURST;
   logic [3:0]  M_AXI_ARCACHE;
   logic [4:0]  M_AXI_ARUSER;
   logic        M_AXI_ARVALID, M_AXI_ARREADY;
   logic [31:0] M_AXI_RDATA;
   logic [1:0]  M_AXI_RRESP;
   logic        M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;
   logic [31:0] M_AXIS_MM2S_TDATA;
   logic [3:0]  M_AXIS_MM2S_TKEEP;
   logic        M_AXIS_MM2S_TLAST, M_AXIS_MM2S_TVALID, M_AXIS_MM2S_TREADY;

   always #5 clk = ~clk;

   axi_mm2s_cmd_engine dut (
      .clk                (clk),
      .rst                (rst),
      .S_AXIS_CMD_TVALID  (S_AXIS_CMD_TVALID),
      .S_AXIS_CMD_TREADY  (S_AXIS_CMD_TREADY),
      .S_AXIS_CMD_TDATA   (S_AXIS_CMD_TDATA),
      .M_AXIS_STS_TVALID  (M_AXIS_STS_TVALID),
      .M_AXIS_STS_TREADY  (M_AXIS_STS_TREADY),
      .M_AXIS_STS_TDATA   (M_AXIS_STS_TDATA),
      .M_AXI_ARADDR       (M_AXI_ARADDR),
      .M_AXI_ARLEN        (M_AXI_ARLEN),
      .M_AXI_ARSIZE       (M_AXI_ARSIZE),
      .M_AXI_ARBURST      (M_AXI_ARBURST),
      .M_AXI_ARCACHE      (M_AXI_ARCACHE),
      .M_AXI_ARUSER       (M_AXI_ARUSER),
      .M_AXI_ARVALID      (M_AXI_ARVALID),
      .M_AXI_ARREADY      (M_AXI_ARREADY),
      .M_AXI_RDATA        (M_AXI_RDATA),
      .M_AXI_RRESP        (M_AXI_RRESP),
      .M_AXI_RLAST        (M_AXI_RLAST),
      .M_AXI_RVALID       (M_AXI_RVALID),
      .M_AXI_RREADY       (M_AXI_RREADY),
      .M_AXIS_MM2S_TDATA  (M_AXIS_MM2S_TDATA),
      .M_AXIS_MM2S_TKEEP  (M_AXIS_MM2S_TKEEP),
      .M_AXIS_MM2S_TLAST  (M_AXIS_MM2S_TLAST),
      .M_AXIS_MM2S_TVALID (M_AXIS_MM2S_TVALID),
      .M_AXIS_MM2S_TREADY (M_AXIS_MM2S_TREADY)
   );

   int errors = 0;
   int checks = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Behavioural read slave; read data is a function of the beat address
   logic [31:0] ar_addr_q[$];
   logic [7:0]  ar_len_q[$];
   bit          s_busy = 1'b0;
   logic [31:0] s_addr = 32'd0;
   int          s_left = 0;
   int          r_beat_cnt = 0;
   int          err_beat = -1;

   initial begin
      M_AXI_ARREADY = 1'b0;
      M_AXI_RVALID  = 1'b0;
      M_AXI_RDATA   = 32'd0;
      M_AXI_RRESP   = 2'b00;
      M_AXI_RLAST   = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) s_busy = 1'b0;
         M_AXI_ARREADY = !s_busy;
         M_AXI_RVALID  = s_busy;
         M_AXI_RDATA   = s_addr ^ PAT;
         M_AXI_RLAST   = s_busy && (s_left == 1);
         M_AXI_RRESP   = (s_busy && r_beat_cnt == err_beat) ? 2'b10 : 2'b00;
         #1;
         if (!rst && M_AXI_ARVALID && M_AXI_ARREADY) begin
            ar_addr_q.push_back(M_AXI_ARADDR);
            ar_len_q.push_back(M_AXI_ARLEN);
            s_busy = 1'b1;
            s_addr = M_AXI_ARADDR;
            s_left = int'(M_AXI_ARLEN) + 1;
         end else if (!rst && M_AXI_RVALID && M_AXI_RREADY) begin
            s_addr = s_addr + 32'd4;
            s_left--;
            r_beat_cnt++;
            if (s_left == 0) s_busy = 1'b0;
         end
      end
   end

   // Stream sink with optional 1-in-3 throttling
   logic [31:0] beat_data[$];
   logic        beat_last[$];
   bit          throttle = 1'b0;
   int          sink_cyc = 0;
   int          mirror_err = 0;
   int          keep_err = 0;

   initial begin
      M_AXIS_MM2S_TREADY = 1'b0;
      forever begin
         @(negedge clk);
         sink_cyc++;
         M_AXIS_MM2S_TREADY = throttle ? (sink_cyc % 3 == 0) : 1'b1;
         #1;
         if (M_AXIS_MM2S_TVALID) begin
            if (M_AXI_RREADY !== M_AXIS_MM2S_TREADY) mirror_err++;
            if (M_AXIS_MM2S_TKEEP !== 4'hF) keep_err++;
         end
         if (!rst && M_AXIS_MM2S_TVALID && M_AXIS_MM2S_TREADY) begin
            beat_data.push_back(M_AXIS_MM2S_TDATA);
            beat_last.push_back(M_AXIS_MM2S_TLAST);
         end
      end
   end

   task automatic send_cmd(input logic [3:0] tag, input logic [31:0] addr,
                           input logic eof, input logic [22:0] btt);
      bit done = 1'b0;
      @(negedge clk);
      S_AXIS_CMD_TDATA  = {4'h0, tag, addr, 1'b0, eof, 7'h00, btt};
      S_AXIS_CMD_TVALID = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         #1;
         if (S_AXIS_CMD_TREADY) done = 1'b1;
         @(negedge clk);
      end
      S_AXIS_CMD_TVALID = 1'b0;
      check_eq("cmd_accept", 64'(done), 64'd1);
   endtask

   task automatic wait_sts(output logic [7:0] d);
      bit got = 1'b0;
      d = 8'h00;
      for (int i = 0; i < 400 && !got; i++) begin
         #1;
         if (M_AXIS_STS_TVALID) begin
            got = 1'b1;
            d   = M_AXIS_STS_TDATA;
         end
         @(negedge clk);
      end
      check_eq("sts_seen", 64'(got), 64'd1);
   endtask

   task automatic check_stream(input string tag, input logic [31:0] base,
                               input int n, input bit eof);
      int derr = 0;
      int lerr = 0;
      check_eq({tag, "_beats"}, 64'(beat_data.size()), 64'(n));
      for (int i = 0; i < beat_data.size() && i < n; i++) begin
         if (beat_data[i] !== ((base + 32'(4 * i)) ^ PAT)) derr++;
         if (beat_last[i] !== (eof && (i == n - 1))) lerr++;
      end
      check_eq({tag, "_data"}, 64'(derr), 64'd0);
      check_eq({tag, "_tlast"}, 64'(lerr), 64'd0);
   endtask

   task automatic clear_logs();
      ar_addr_q.delete();
      ar_len_q.delete();
      beat_data.delete();
      beat_last.delete();
      r_beat_cnt = 0;
      mirror_err = 0;
   endtask

   logic [7:0] sts;

   initial begin
      logic [22:0] bad_btt [3];
      logic [31:0] bad_addr[3];
      int          instab;
      bit          hit;

      rst               = 1'b1;
      S_AXIS_CMD_TVALID = 1'b0;
      S_AXIS_CMD_TDATA  = 72'd0;
      M_AXIS_STS_TREADY = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      check_eq("rst_cmd_tready", 64'(S_AXIS_CMD_TREADY), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #2;
      check_eq("idle_cmd_tready", 64'(S_AXIS_CMD_TREADY), 64'd1);
      check_eq("idle_arvalid", 64'(M_AXI_ARVALID), 64'd0);
      check_eq("idle_sts_valid", 64'(M_AXIS_STS_TVALID), 64'd0);
      check_eq("idle_mm2s_valid", 64'(M_AXIS_MM2S_TVALID), 64'd0);
      check_eq("idle_rready", 64'(M_AXI_RREADY), 64'd0);
      check_eq("const_ar", 64'({M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARCACHE, M_AXI_ARUSER}),
               64'({3'b010, 2'b01, 4'b0011, 5'b00001}));

      // Single aligned 16-beat burst with exact ARVALID timing
      clear_logs();
      send_cmd(4'd3, 32'h1000_0000, 1'b1, 23'd64);
      #1;
      check_eq("t1_arvalid_early", 64'(M_AXI_ARVALID), 64'd0);
      @(negedge clk);
      #1;
      check_eq("t1_arvalid", 64'(M_AXI_ARVALID), 64'd1);
      @(negedge clk);
      wait_sts(sts);
      check_eq("t1_status", 64'(sts), 64'h83);
      check_eq("t1_nbursts", 64'(ar_addr_q.size()), 64'd1);
      if (ar_addr_q.size() >= 1) begin
         check_eq("t1_araddr", 64'(ar_addr_q[0]), 64'h1000_0000);
         check_eq("t1_arlen", 64'(ar_len_q[0]), 64'd15);
      end
      check_stream("t1", 32'h1000_0000, 16, 1'b1);

      // 4 KB boundary split
      clear_logs();
      send_cmd(4'd1, 32'h1000_0FF0, 1'b1, 23'd64);
      wait_sts(sts);
      check_eq("t2_status", 64'(sts), 64'h81);
      check_eq("t2_nbursts", 64'(ar_addr_q.size()), 64'd2);
      if (ar_addr_q.size() >= 2) begin
         check_eq("t2_araddr0", 64'(ar_addr_q[0]), 64'h1000_0FF0);
         check_eq("t2_arlen0", 64'(ar_len_q[0]), 64'd3);
         check_eq("t2_araddr1", 64'(ar_addr_q[1]), 64'h1000_1000);
         check_eq("t2_arlen1", 64'(ar_len_q[1]), 64'd11);
      end
      check_stream("t2", 32'h1000_0FF0, 16, 1'b1);

      // SLVERR on beat 5, all data still forwarded
      clear_logs();
      err_beat = 4;
      send_cmd(4'd7, 32'h2000_0000, 1'b1, 23'd32);
      wait_sts(sts);
      err_beat = -1;
      check_eq("t3_status", 64'(sts), 64'h47);
      check_stream("t3", 32'h2000_0000, 8, 1'b1);

      // Malformed commands return INTERR without AXI traffic
      bad_btt[0] = 23'd0;  bad_addr[0] = 32'h1000_0000;
      bad_btt[1] = 23'd16; bad_addr[1] = 32'h1000_0002;
      bad_btt[2] = 23'd6;  bad_addr[2] = 32'h1000_0000;
      for (int k = 0; k < 3; k++) begin
         clear_logs();
         send_cmd(4'd2, bad_addr[k], 1'b1, bad_btt[k]);
         #1;
         check_eq($sformatf("t4_%0d_sts_early", k), 64'(M_AXIS_STS_TVALID), 64'd0);
         @(negedge clk);
         #1;
         check_eq($sformatf("t4_%0d_sts_valid", k), 64'(M_AXIS_STS_TVALID), 64'd1);
         check_eq($sformatf("t4_%0d_status", k), 64'(M_AXIS_STS_TDATA), 64'h12);
         @(negedge clk);
         check_eq($sformatf("t4_%0d_nbursts", k), 64'(ar_addr_q.size()), 64'd0);
      end

      // Throttled stream, EOF=0, stalled status
      clear_logs();
      throttle          = 1'b1;
      M_AXIS_STS_TREADY = 1'b0;
      send_cmd(4'd5, 32'h3000_0000, 1'b0, 23'd40);
      wait_sts(sts);
      check_eq("t5_status", 64'(sts), 64'h85);
      instab = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (!M_AXIS_STS_TVALID || M_AXIS_STS_TDATA !== sts) instab++;
         @(negedge clk);
      end
      check_eq("t5_sts_stable", 64'(instab), 64'd0);
      M_AXIS_STS_TREADY = 1'b1;
      @(negedge clk);
      #1;
      check_eq("t5_sts_done", 64'(M_AXIS_STS_TVALID), 64'd0);
      throttle = 1'b0;
      check_eq("t5_rready_mirror", 64'(mirror_err), 64'd0);
      check_eq("t5_nbursts", 64'(ar_len_q.size()), 64'd1);
      if (ar_len_q.size() >= 1) check_eq("t5_arlen", 64'(ar_len_q[0]), 64'd9);
      check_stream("t5", 32'h3000_0000, 10, 1'b0);
      check_eq("tkeep", 64'(keep_err), 64'd0);

      // Reset mid-burst, then a clean command
      @(negedge clk);
      clear_logs();
      send_cmd(4'd9, 32'h4000_0000, 1'b1, 23'd64);
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(negedge clk);
         #2;
         if (beat_data.size() >= 3) hit = 1'b1;
      end
      check_eq("t6_reached_beat3", 64'(hit), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check_eq("t6_valids", 64'({M_AXI_ARVALID, M_AXIS_MM2S_TVALID, M_AXIS_STS_TVALID,
                                 M_AXI_RREADY, S_AXIS_CMD_TREADY}), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      #1;
      check_eq("t6_cmd_tready", 64'(S_AXIS_CMD_TREADY), 64'd1);
      clear_logs();
      send_cmd(4'd4, 32'h5000_0000, 1'b1, 23'd16);
      wait_sts(sts);
      check_eq("t6_status", 64'(sts), 64'h84);
      check_eq("t6_nbursts", 64'(ar_len_q.size()), 64'd1);
      if (ar_len_q.size() >= 1) check_eq("t6_arlen", 64'(ar_len_q[0]), 64'd3);
      check_stream("t6", 32'h5000_0000, 4, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
